// File: rtl/lcd_ctrl.sv
// lcd_ctrl: Avalon-MM slave feeding an HD44780 8-bit LCD bus from a
// command/data FIFO, with an optional power-on init sequence.
module lcd_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int INIT_EN     = 1,
  parameter int T_POWERUP   = 750000,
  parameter int T_AS        = 3,
  parameter int T_PW        = 12,
  parameter int T_H         = 2,
  parameter int T_EXEC      = 2500,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic       read_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  localparam int TMAX = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;

  localparam logic [CW-1:0] C_PU  = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] C_AS  = CW'(T_AS - 1);
  localparam logic [CW-1:0] C_PW  = CW'(T_PW - 1);
  localparam logic [CW-1:0] C_H   = CW'(T_H - 1);
  localparam logic [CW-1:0] C_EX  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] C_EXL = CW'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          e_q, e_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q;

  logic       wr, push, push_ok, pop;
  logic       full, empty, busy, tdone, long_x;
  logic [2:0] nidx;
  logic [8:0] rd_ent;

  function automatic logic [7:0] rom_f(input logic [2:0] i);
    unique case (i)
      3'd0, 3'd1, 3'd2: rom_f = 8'h38;
      3'd3:             rom_f = 8'h0C;
      3'd4:             rom_f = 8'h01;
      default:          rom_f = 8'h06;
    endcase
  endfunction

  assign wr      = chipselect & ~write_n;
  assign push    = wr & ~address[1];
  assign full    = (lvl_q == LW'(FIFO_DEPTH));
  assign empty   = (lvl_q == '0);
  assign push_ok = push & ~full;
  assign rd_ent  = mem_q[rp_q];
  assign busy    = ~empty | (state_q != S_IDLE);
  assign tdone   = (cnt_q == '0);
  assign nidx    = idx_q + 3'd1;
  // Init entries and clear/home commands need the long execution wait.
  assign long_x  = ~done_q |
                   (~rs_q & (data_q[7:2] == 6'd0) & (data_q[1:0] != 2'd0));

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= {address[0], writedata};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop)     rp_q <= rp_q + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr && address == 2'd2) ovf_d = 1'b0;
    if (push && full)          ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_POWERUP;
      cnt_q   <= C_PU;
      idx_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tdone ? cnt_q : cnt_q - 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    e_d     = e_q;
    done_d  = done_q;
    pop     = 1'b0;
    unique case (state_q)
      S_POWERUP: begin
        if (tdone) begin
          if (INIT_EN != 0) begin
            state_d = S_INIT;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_INIT: begin
        data_d  = rom_f(idx_q);
        rs_d    = 1'b0;
        cnt_d   = C_AS;
        state_d = S_SETUP;
      end
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = rd_ent[7:0];
          rs_d    = rd_ent[8];
          cnt_d   = C_AS;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tdone) begin
          e_d     = 1'b1;
          cnt_d   = C_PW;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (tdone) begin
          e_d     = 1'b0;
          cnt_d   = C_H;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tdone) begin
          cnt_d   = long_x ? C_EXL : C_EX;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (tdone) begin
          if (done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == 3'd5) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Init entries chain straight into the next setup phase.
            idx_d   = nidx;
            data_d  = rom_f(nidx);
            rs_d    = 1'b0;
            cnt_d   = C_AS;
            state_d = S_SETUP;
          end
        end
      end
      default: state_d = S_POWERUP;
    endcase
  end

  always_comb begin
    readdata = '0;
    if (chipselect && !read_n) begin
      unique case (address)
        2'd2:    readdata = {4'b0, ovf_q, done_q, full, busy};
        2'd3:    readdata = {{(8 - LW){1'b0}}, lvl_q};
        default: readdata = '0;
      endcase
    end
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed bench for lcd_ctrl; dut_a runs the init
// sequence, dut_b (no init) is used for the bus-side scenarios.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic       read_n;
  logic [7:0] writedata;

  logic [7:0] a_rd, a_data, b_rd, b_data;
  logic       a_rs, a_rw, a_e, b_rs, b_rw, b_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  lcd_ctrl #(
    .FIFO_DEPTH(4), .INIT_EN(1), .T_POWERUP(10), .T_AS(2),
    .T_PW(3), .T_H(1), .T_EXEC(5), .T_EXEC_LONG(20)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(a_rd), .lcd_data(a_data),
    .lcd_rs(a_rs), .lcd_rw(a_rw), .lcd_e(a_e)
  );

  lcd_ctrl #(
    .FIFO_DEPTH(4), .INIT_EN(0), .T_POWERUP(10), .T_AS(2),
    .T_PW(3), .T_H(1), .T_EXEC(5), .T_EXEC_LONG(20)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .read_n(read_n),
    .writedata(writedata), .readdata(b_rd), .lcd_data(b_data),
    .lcd_rs(b_rs), .lcd_rw(b_rw), .lcd_e(b_e)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic e_of(input bit w);
    return w ? b_e : a_e;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input bit w,
                    output logic [7:0] v);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    #1;
    v          = w ? b_rd : a_rd;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic wait_e(input bit w, input logic lv, input int bound,
                        input string tag, output int t);
    int n = 0;
    while (e_of(w) !== lv && n < bound) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    chk(tag, 32'(e_of(w) === lv), 32'd1);
  endtask

  task automatic wait_idle(input int bound, input string tag,
                           output int t);
    logic [7:0] v;
    int n = 0;
    rd(2'd2, 1'b1, v);
    while (v[0] && n < bound) begin
      @(negedge clk);
      rd(2'd2, 1'b1, v);
      n++;
    end
    t = cyc;
    chk(tag, 32'(v[0]), 32'd0);
  endtask

  task automatic count_pulses(input int win, output int n,
                              output logic [7:0] got [8]);
    logic pe;
    n  = 0;
    pe = b_e;
    for (int i = 0; i < 8; i++) got[i] = '0;
    repeat (win) begin
      @(negedge clk);
      if (b_e && !pe) begin
        if (n < 8) got[n] = b_data;
        n++;
      end
      pe = b_e;
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] got [8];
    int c0, tr, tf, prev, td, tb, n, f;

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);

    chk("rst_a_e", 32'(a_e), 0);
    chk("rst_a_data", 32'(a_data), 0);
    chk("rst_a_rs", 32'(a_rs), 0);
    chk("rst_a_rw", 32'(a_rw), 0);
    chk("rst_b_rw", 32'(b_rw), 0);
    rd(2'd2, 1'b0, v); chk("rst_a_status", 32'(v), 32'h01);
    rd(2'd2, 1'b1, v); chk("rst_b_status", 32'(v), 32'h01);
    rd(2'd3, 1'b1, v); chk("rst_b_level", 32'(v), 0);

    // Scenario 1: init sequence on dut_a
    reset_n = 1'b1;
    c0   = cyc;
    prev = c0;
    for (int k = 0; k < 6; k++) begin
      wait_e(1'b0, 1'b1, 60, "t1_rise_to", tr);
      if (k == 0) chk("t1_first_rise", 32'(tr - c0), 32'd13);
      else        chk("t1_spacing", 32'(tr - prev), 32'd26);
      chk("t1_data", 32'(a_data), 32'(rom[k]));
      chk("t1_rs", 32'(a_rs), 0);
      wait_e(1'b0, 1'b0, 10, "t1_fall_to", tf);
      chk("t1_width", 32'(tf - tr), 32'd3);
      prev = tr;
    end
    repeat (25) @(negedge clk);
    rd(2'd2, 1'b0, v); chk("t1_a_status", 32'(v), 32'h04);
    rd(2'd2, 1'b1, v); chk("t1_b_status", 32'(v), 32'h04);

    // Scenario 2: single data write
    wr(2'd1, 8'h41);
    rd(2'd3, 1'b1, v); chk("t2_level", 32'(v), 1);
    rd(2'd2, 1'b1, v); chk("t2_status", 32'(v), 32'h05);
    n = 0;
    while (!(b_data == 8'h41 && b_rs) && n < 10) begin
      @(negedge clk);
      n++;
    end
    td = cyc;
    wait_e(1'b1, 1'b1, 20, "t2_rise_to", tr);
    chk("t2_setup", 32'(tr - td), 32'd2);
    chk("t2_rs", 32'(b_rs), 1);
    chk("t2_data", 32'(b_data), 32'h41);
    wait_e(1'b1, 1'b0, 10, "t2_fall_to", tf);
    chk("t2_width", 32'(tf - tr), 32'd3);
    wait_idle(30, "t2_idle_to", tb);
    chk("t2_busy_clear", 32'(tb - tf), 32'd6);

    // Scenario 3: clear command followed by data
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h42);
    wait_e(1'b1, 1'b1, 20, "t3_rise1_to", tr);
    chk("t3_data1", 32'(b_data), 32'h01);
    chk("t3_rs1", 32'(b_rs), 0);
    wait_e(1'b1, 1'b0, 10, "t3_fall1_to", tf);
    wait_e(1'b1, 1'b1, 40, "t3_rise2_to", tr);
    chk("t3_gap", 32'(tr - tf), 32'd24);
    chk("t3_data2", 32'(b_data), 32'h42);
    chk("t3_rs2", 32'(b_rs), 1);
    wait_idle(40, "t3_idle_to", tb);

    // Scenario 4: overflow while stalled in a long exec
    wr(2'd0, 8'h01);
    wait_e(1'b1, 1'b1, 20, "t4_rise_to", tr);
    wait_e(1'b1, 1'b0, 10, "t4_fall_to", tf);
    for (int i = 0; i < 5; i++) wr(2'd1, 8'h50 + 8'(i));
    rd(2'd3, 1'b1, v); chk("t4_level", 32'(v), 4);
    rd(2'd2, 1'b1, v); chk("t4_status_ovf", 32'(v), 32'h0F);
    wr(2'd2, 8'h00);
    rd(2'd2, 1'b1, v); chk("t4_status_clr", 32'(v), 32'h07);
    count_pulses(120, n, got);
    chk("t4_pulses", 32'(n), 4);
    for (int i = 0; i < 4; i++)
      chk("t4_order", 32'(got[i]), 32'h50 + 32'(i));
    rd(2'd3, 1'b1, v); chk("t4_level_end", 32'(v), 0);

    // Scenario 5: push into a full FIFO on the pop edge
    wr(2'd0, 8'h01);
    wait_e(1'b1, 1'b1, 20, "t5_rise_to", tr);
    wait_e(1'b1, 1'b0, 10, "t5_fall_to", f);
    for (int i = 0; i < 4; i++) wr(2'd1, 8'h60 + 8'(i));
    rd(2'd2, 1'b1, v); chk("t5_status_full", 32'(v), 32'h07);
    while (cyc < f + 21) @(negedge clk);
    wr(2'd1, 8'h6F);
    rd(2'd3, 1'b1, v); chk("t5_level", 32'(v), 3);
    rd(2'd2, 1'b1, v); chk("t5_status", 32'(v), 32'h0D);
    count_pulses(120, n, got);
    chk("t5_pulses", 32'(n), 4);
    for (int i = 0; i < 4; i++)
      chk("t5_order", 32'(got[i]), 32'h60 + 32'(i));
    wr(2'd2, 8'h00);

    // Scenario 6: reset during the enable pulse
    wr(2'd1, 8'h70);
    wr(2'd1, 8'h71);
    wait_e(1'b1, 1'b1, 20, "t6_rise_to", tr);
    rd(2'd3, 1'b1, v); chk("t6_level_pre", 32'(v), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_e", 32'(b_e), 0);
    chk("t6_data", 32'(b_data), 0);
    chk("t6_rs", 32'(b_rs), 0);
    rd(2'd3, 1'b1, v); chk("t6_level", 32'(v), 0);
    rd(2'd2, 1'b1, v); chk("t6_status", 32'(v), 32'h01);
    reset_n = 1'b1;
    c0 = cyc;
    n  = 0;
    rd(2'd2, 1'b1, v);
    while (!v[2] && n < 40) begin
      @(negedge clk);
      rd(2'd2, 1'b1, v);
      n++;
    end
    chk("t6_powerup", 32'(cyc - c0), 32'd10);
    count_pulses(40, n, got);
    chk("t6_no_pulse", 32'(n), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
